// File: rtl/sevenseg_scan_if.sv
// Converter-to-display bus: BCD digits with a ready flag in, anode/segment drive and frame pulse out.
// Latency: none (wires only); timing is owned by the scanner behind the slave modport.
// Backpressure: none; the scanner samples digits only on its own frame boundary.
interface sevenseg_scan_if;
  logic       ready;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] C;
  logic [3:0] D;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame;

  // Converter / stimulus side
  modport master (output ready, A, B, C, D, input an, seg, frame);
  // Display scanner side
  modport slave  (input ready, A, B, C, D, output an, seg, frame);
endinterface

// File: rtl/sevenseg_scan.sv
// Purpose: latch BCD digits at frame boundaries and time-multiplex them onto a 4-digit common-anode display.
// Latency: an/seg/frame are registered, 1 cycle behind the slot counter and shadow state.
// Backpressure: none; digits are sampled only on the frame-boundary cycle when ready is high, else ignored.
// Optional: define SEVENSEG_LEADING_ZERO_BLANK_EN to suppress leading zeros in slots A..C.
module sevenseg_scan #(
  parameter int REFRESH_COUNT = 2000, // cycles per digit slot, >= 2
  parameter int BLANK_CYCLES  = 16,   // dark cycles at slot start, < REFRESH_COUNT
  parameter int CNT_WIDTH     = 11    // must hold REFRESH_COUNT-1
) (
  input logic            clk,
  input logic            rst,
  sevenseg_scan_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(REFRESH_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] BLANK_LIM = CNT_WIDTH'(BLANK_CYCLES);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           sel_q, sel_d;
  // shadow_q[0] = A (thousands) ... shadow_q[3] = D (units), indexed by sel
  logic [3:0][3:0]      shadow_q, shadow_d;
  logic                 valid_q, valid_d;
  logic [3:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 frame_q, frame_d;

  logic                 cnt_wrap;
  logic                 boundary;
  logic                 lz_blank;

  // Active-low {a,b,c,d,e,f,g}; non-BCD codes show a lone dash on g.
  function automatic logic [6:0] decode(input logic [3:0] dig);
    logic [6:0] s;
    case (dig)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111110;
    endcase
    return s;
  endfunction

  // Leading-zero suppression: a slot goes dark when it and every slot to its left hold zero;
  // the units digit always shows so a value of zero still reads "0".
  always_comb begin
    lz_blank = 1'b0;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    case (sel_q)
      2'd0:    lz_blank = (shadow_q[0] == 4'd0);
      2'd1:    lz_blank = (shadow_q[0] == 4'd0) && (shadow_q[1] == 4'd0);
      2'd2:    lz_blank = (shadow_q[0] == 4'd0) && (shadow_q[1] == 4'd0) &&
                          (shadow_q[2] == 4'd0);
      default: lz_blank = 1'b0;
    endcase
`endif
  end

  // Slot counter, frame-synchronous shadow load and registered output selection.
  always_comb begin
    cnt_wrap = (cnt_q == CNT_MAX);
    boundary = cnt_wrap && (sel_q == 2'd3);

    cnt_d    = cnt_wrap ? '0 : cnt_q + CNT_WIDTH'(1);
    sel_d    = cnt_wrap ? sel_q + 2'd1 : sel_q;

    // Only the last cycle of slot D may load new digits, so a frame never mixes two digit sets.
    shadow_d = shadow_q;
    valid_d  = valid_q;
    if (boundary && bus.ready) begin
      shadow_d = {bus.D, bus.C, bus.B, bus.A};
      valid_d  = 1'b1;
    end

    frame_d  = boundary;

    // Dead time at the start of each slot lets the previous anode turn off before new segments drive.
    an_d     = 4'b1111;
    seg_d    = 7'b1111111;
    if (valid_q && (cnt_q >= BLANK_LIM) && !lz_blank) begin
      an_d  = ~(4'b1000 >> sel_q);
      seg_d = decode(shadow_q[sel_q]);
    end
  end

  // State and output registers with synchronous reset to a dark display.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      sel_q    <= 2'd0;
      shadow_q <= '0;
      valid_q  <= 1'b0;
      an_q     <= 4'b1111;
      seg_q    <= 7'b1111111;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      valid_q  <= valid_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan with a small-parameter build and a cycle-indexed reference model.
// Latency: model predicts the registered outputs seen #1 after each rising edge.
// Backpressure: none; stimulus drives ready/digits freely every cycle.
module tb_sevenseg_scan;
  localparam int RC    = 8;
  localparam int BC    = 2;
  localparam int CW    = 3;
  localparam int FRAME = 4 * RC;

  logic clk;
  logic rst;
  sevenseg_scan_if bus ();

  sevenseg_scan #(.REFRESH_COUNT(RC), .BLANK_CYCLES(BC), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles since reset, latched digits (0=A..3=D), display-enabled flag.
  int         m_k;
  logic [3:0] m_sh [4];
  bit         m_valid;
  logic [6:0] seg_tab [16];
  logic [3:0] an_tab  [4];

  function automatic logic [3:0] rdig();
    if ($urandom_range(0, 2) == 0) return 4'd0;
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic drive(input logic r, input logic [3:0] a, b, c, d);
    bus.ready = r;
    bus.A = a;
    bus.B = b;
    bus.C = c;
    bus.D = d;
  endtask

  // Predict outputs after the coming edge from the current model state and inputs, then advance.
  task automatic predict(output logic [3:0] e_an, output logic [6:0] e_seg, output logic e_fr);
    int slot;
    int pos;
    bit blank;
    bit allz;
    if (rst) begin
      e_an = 4'hF; e_seg = 7'h7F; e_fr = 1'b0;
      m_k = 0; m_valid = 0;
      for (int i = 0; i < 4; i++) m_sh[i] = 4'd0;
      return;
    end
    slot  = (m_k / RC) % 4;
    pos   = m_k % RC;
    blank = !m_valid || (pos < BC);
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    if (slot < 3) begin
      allz = 1;
      for (int i = 0; i <= slot; i++) if (m_sh[i] != 4'd0) allz = 0;
      if (allz) blank = 1;
    end
`else
    allz = 0;
`endif
    e_an  = blank ? 4'hF  : an_tab[slot];
    e_seg = blank ? 7'h7F : seg_tab[m_sh[slot]];
    e_fr  = ((m_k % FRAME) == FRAME - 1);
    if (e_fr && bus.ready) begin
      m_sh[0] = bus.A; m_sh[1] = bus.B; m_sh[2] = bus.C; m_sh[3] = bus.D;
      m_valid = 1;
    end
    m_k++;
  endtask

  // Step until the model sits on a frame-boundary cycle (no comparisons).
  task automatic advance_to_boundary();
    logic [3:0] ea; logic [6:0] es; logic ef;
    bus.ready = 1'b0;
    while ((m_k % FRAME) != FRAME - 1) begin
      predict(ea, es, ef);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [3:0] ea; logic [6:0] es; logic ef;
    int pulses, first, last;
    rst = 1'b1;
    drive(1'b1, rdig(), rdig(), rdig(), rdig());
    for (int i = 0; i < 2; i++) begin
      predict(ea, es, ef);
      @(posedge clk); #1;
      checks++;
      if ({bus.an, bus.seg, bus.frame} !== {4'hF, 7'h7F, 1'b0}) begin
        errors++;
        $display("FAIL reset_state got an=%b seg=%b frame=%b want 1111 1111111 0", bus.an, bus.seg, bus.frame);
      end
    end
    rst = 1'b0;
    pulses = 0; first = -1; last = -1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      drive(1'b0, rdig(), rdig(), rdig(), rdig());
      predict(ea, es, ef);
      @(posedge clk); #1;
      checks++;
      if ({bus.an, bus.seg, bus.frame} !== {ea, es, ef}) begin
        errors++;
        $display("FAIL idle_dark k=%0d got %b/%b/%b want %b/%b/%b", m_k - 1, bus.an, bus.seg, bus.frame, ea, es, ef);
      end
      if (bus.frame === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (i - last != FRAME) begin
            errors++;
            $display("FAIL frame_spacing got %0d want %0d", i - last, FRAME);
          end
        end
        if (first < 0) first = i;
        last = i;
        pulses++;
      end
    end
    checks++;
    if (pulses != 3 || first != FRAME - 1) begin
      errors++;
      $display("FAIL frame_count got %0d pulses first at %0d want 3 first at %0d", pulses, first, FRAME - 1);
    end
  endtask

  task automatic test_capture();
    logic [3:0] ea; logic [6:0] es; logic ef;
    int n_a, n_d;
    n_a = 0; n_d = 0;
    advance_to_boundary();
    drive(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
    for (int i = 0; i <= FRAME; i++) begin
      if (i == 1) drive(1'b0, rdig(), rdig(), rdig(), rdig());
      predict(ea, es, ef);
      @(posedge clk); #1;
      checks++;
      if ({bus.an, bus.seg, bus.frame} !== {ea, es, ef}) begin
        errors++;
        $display("FAIL capture k=%0d got %b/%b/%b want %b/%b/%b", m_k - 1, bus.an, bus.seg, bus.frame, ea, es, ef);
      end
      if (bus.an === 4'b0111 && bus.seg === 7'b1001111) n_a++;
      if (bus.an === 4'b1110 && bus.seg === 7'b1001100) n_d++;
    end
    checks++;
    if (n_a != RC - BC || n_d != RC - BC) begin
      errors++;
      $display("FAIL capture_slots got A=%0d D=%0d lit cycles want %0d each", n_a, n_d, RC - BC);
    end
  endtask

  task automatic test_midframe();
    logic [3:0] ea; logic [6:0] es; logic ef;
    int n_old, n_a, n_d;
    n_old = 0; n_a = 0; n_d = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i == FRAME / 2) drive(1'b1, 4'd9, 4'd8, 4'd7, 4'd6);
      if (i == FRAME)     drive(1'b0, rdig(), rdig(), rdig(), rdig());
      predict(ea, es, ef);
      @(posedge clk); #1;
      checks++;
      if ({bus.an, bus.seg, bus.frame} !== {ea, es, ef}) begin
        errors++;
        $display("FAIL midframe k=%0d got %b/%b/%b want %b/%b/%b", m_k - 1, bus.an, bus.seg, bus.frame, ea, es, ef);
      end
      if (i < FRAME && bus.an === 4'b1110 && bus.seg === 7'b1001100) n_old++;
      if (i >= FRAME && bus.an === 4'b0111 && bus.seg === 7'b0000100) n_a++;
      if (i >= FRAME && bus.an === 4'b1110 && bus.seg === 7'b0100000) n_d++;
    end
    checks++;
    if (n_old != RC - BC || n_a != RC - BC || n_d != RC - BC) begin
      errors++;
      $display("FAIL midframe_tear got old_D=%0d new_A=%0d new_D=%0d want %0d each", n_old, n_a, n_d, RC - BC);
    end
  endtask

  task automatic test_non_bcd();
    logic [3:0] ea; logic [6:0] es; logic ef;
    int n_dash;
    n_dash = 0;
    advance_to_boundary();
    drive(1'b1, 4'd1, 4'd2, 4'd3, 4'hC);
    for (int i = 0; i <= FRAME; i++) begin
      if (i == 1) drive(1'b0, rdig(), rdig(), rdig(), rdig());
      predict(ea, es, ef);
      @(posedge clk); #1;
      checks++;
      if ({bus.an, bus.seg, bus.frame} !== {ea, es, ef}) begin
        errors++;
        $display("FAIL non_bcd k=%0d got %b/%b/%b want %b/%b/%b", m_k - 1, bus.an, bus.seg, bus.frame, ea, es, ef);
      end
      if (bus.an === 4'b1110 && bus.seg === 7'b1111110) n_dash++;
    end
    checks++;
    if (n_dash != RC - BC) begin
      errors++;
      $display("FAIL non_bcd_dash got %0d dash cycles want %0d", n_dash, RC - BC);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ea; logic [6:0] es; logic ef;
    int lit;
    lit = 0;
    for (int i = 0; i < RC + 3; i++) begin
      drive(1'b1, rdig(), rdig(), rdig(), rdig());
      predict(ea, es, ef);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    predict(ea, es, ef);
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({bus.an, bus.seg, bus.frame} !== {4'hF, 7'h7F, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid got an=%b seg=%b frame=%b want 1111 1111111 0", bus.an, bus.seg, bus.frame);
    end
    for (int i = 0; i < FRAME + 8; i++) begin
      drive(1'b0, rdig(), rdig(), rdig(), rdig());
      predict(ea, es, ef);
      @(posedge clk); #1;
      checks++;
      if ({bus.an, bus.seg, bus.frame} !== {ea, es, ef}) begin
        errors++;
        $display("FAIL post_reset k=%0d got %b/%b/%b want %b/%b/%b", m_k - 1, bus.an, bus.seg, bus.frame, ea, es, ef);
      end
      if (bus.an !== 4'hF) lit++;
    end
    checks++;
    if (lit != 0) begin
      errors++;
      $display("FAIL post_reset_dark got %0d lit cycles want 0", lit);
    end
    advance_to_boundary();
    drive(1'b1, 4'd5, 4'd0, 4'd2, 4'd8);
    for (int i = 0; i <= FRAME; i++) begin
      if (i == 1) drive(1'b0, rdig(), rdig(), rdig(), rdig());
      predict(ea, es, ef);
      @(posedge clk); #1;
      checks++;
      if ({bus.an, bus.seg, bus.frame} !== {ea, es, ef}) begin
        errors++;
        $display("FAIL relatch k=%0d got %b/%b/%b want %b/%b/%b", m_k - 1, bus.an, bus.seg, bus.frame, ea, es, ef);
      end
    end
  endtask

  task automatic test_zero();
    logic [3:0] ea; logic [6:0] es; logic ef;
    logic [3:0] dval;
    int other, n_d, n_zero;
    for (int pass = 0; pass < 2; pass++) begin
      dval = (pass == 0) ? 4'd7 : 4'd0;
      other = 0; n_d = 0; n_zero = 0;
      advance_to_boundary();
      drive(1'b1, 4'd0, 4'd0, 4'd0, dval);
      for (int i = 0; i <= FRAME; i++) begin
        if (i == 1) drive(1'b0, rdig(), rdig(), rdig(), rdig());
        predict(ea, es, ef);
        @(posedge clk); #1;
        checks++;
        if ({bus.an, bus.seg, bus.frame} !== {ea, es, ef}) begin
          errors++;
          $display("FAIL zero k=%0d got %b/%b/%b want %b/%b/%b", m_k - 1, bus.an, bus.seg, bus.frame, ea, es, ef);
        end
        if (i > 0 && bus.an !== 4'hF && bus.an !== 4'b1110) other++;
        if (i > 0 && bus.an === 4'b1110 && bus.seg === seg_tab[dval]) n_d++;
        if (i > 0 && bus.an !== 4'hF && bus.seg === 7'b0000001) n_zero++;
      end
      checks++;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
      if (other != 0 || n_d != RC - BC) begin
        errors++;
        $display("FAIL zero_blank d=%0d got other=%0d d_lit=%0d want 0 and %0d", dval, other, n_d, RC - BC);
      end
`else
      if (other != 3 * (RC - BC) || n_d != RC - BC || n_zero != ((dval == 0) ? 4 : 3) * (RC - BC)) begin
        errors++;
        $display("FAIL zero_show d=%0d got other=%0d d_lit=%0d zeros=%0d", dval, other, n_d, n_zero);
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [3:0] ea; logic [6:0] es; logic ef;
    for (int i = 0; i < 10 * FRAME; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive(($urandom_range(0, 2) == 0), rdig(), rdig(), rdig(), rdig());
      predict(ea, es, ef);
      @(posedge clk); #1;
      checks++;
      if ({bus.an, bus.seg, bus.frame} !== {ea, es, ef}) begin
        errors++;
        $display("FAIL random k=%0d got %b/%b/%b want %b/%b/%b", m_k - 1, bus.an, bus.seg, bus.frame, ea, es, ef);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] ea; logic [6:0] es; logic ef;
    for (int i = 0; i < 5 * FRAME; i++) begin
      drive(1'b1, rdig(), rdig(), rdig(), rdig());
      predict(ea, es, ef);
      @(posedge clk); #1;
      checks++;
      if ({bus.an, bus.seg, bus.frame} !== {ea, es, ef}) begin
        errors++;
        $display("FAIL back_to_back k=%0d got %b/%b/%b want %b/%b/%b", m_k - 1, bus.an, bus.seg, bus.frame, ea, es, ef);
      end
    end
  endtask

  initial begin
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b1111110, 7'b1111110,
                7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110};
    an_tab  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    m_k = 0;
    m_valid = 0;
    for (int i = 0; i < 4; i++) m_sh[i] = 4'd0;
    rst = 1'b1;
    drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    #2;
    test_reset();
    test_capture();
    test_midframe();
    test_non_bcd();
    test_reset_mid();
    test_zero();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
- Downstream consumer of the 4-digit BCD converter.
- Captures the four BCD digits (A = thousands ... D = units) when the converter flags ready.
- Holds the digits in a shadow register and time-multiplexes them onto the board's 4-digit common-anode seven-segment display.
- Includes per-digit dead-time blanking against ghosting, and frame-synchronous updates so a digit set never tears mid-frame.

Parameters:
- REFRESH_COUNT, 2000: clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off; must be < REFRESH_COUNT.
- CNT_WIDTH, 11: slot counter width; must hold REFRESH_COUNT-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset.
- ready  input  1  converter result valid on A..D.
- A  input  4  BCD thousands digit.
- B  input  4  BCD hundreds digit.
- C  input  4  BCD tens digit.
- D  input  4  BCD units digit.
- an  output  4  anode enables, active-low; an[3] = leftmost (A) ... an[0] = D.
- seg  output  7  segments {a,b,c,d,e,f,g}, active-low.
- frame  output  1  one-cycle pulse at the start of each display frame.

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- Reset values: cnt=0, sel=0, shadow digits=0, valid=0, an=4'b1111, seg=7'b1111111, frame=0.
- Slot counter:
  - cnt increments every cycle.
  - When cnt==REFRESH_COUNT-1: cnt->0 and sel->sel+1 mod 4.
  - sel mapping: 0=A/an[3], 1=B/an[2], 2=C/an[1], 3=D/an[0].
- Frame boundary is the cycle with cnt==REFRESH_COUNT-1 and sel==3. On that cycle:
  - If ready==1: shadow<=A,B,C,D and valid<=1.
  - If ready==0: shadow and valid are unchanged.
  - frame is registered high for exactly the next cycle (the first cycle of sel=0). There is no frame pulse out of reset.
- Digit inputs are ignored outside the boundary cycle, regardless of ready.
- Outputs an, seg and frame are registered. an/seg at cycle t+1 reflect cnt/sel/shadow/valid at cycle t (latency 1).
- Output selection:
  - valid==0: an=1111, seg=1111111.
  - cnt<BLANK_CYCLES: an=1111, seg=1111111.
  - Otherwise: the selected anode bit is 0, the other three are 1, and seg is the decoded shadow digit of slot sel.
- Decode table, active-low {a..g}:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - 10..15 (non-BCD) = 1111110 (dash, segment g only).
- Reset mid-operation returns everything to reset values on the next edge. Valid is cleared, so the display stays dark until a boundary cycle sees ready==1.
- ready held high continuously: the shadow reloads at every frame boundary.
- Scan period: 4*REFRESH_COUNT cycles per frame; at 8 MHz with default parameters, that is 1 kHz frames.

Optional Feature:
- Macro: SEVENSEG_LEADING_ZERO_BLANK_EN.
- When defined, leading zeros are suppressed:
  - Slot A is blanked if shadow A==0.
  - Slot B is blanked if A==0 and B==0.
  - Slot C is blanked if A==0, B==0 and C==0.
  - Slot D is never blanked.
  - Blanked means an=1111 and seg=1111111 for that whole slot.
  - Non-BCD codes (10..15) count as non-zero.
- When undefined, all four digits are always shown, zeros included.

Test Plan (REFRESH_COUNT=8, BLANK_CYCLES=2, CNT_WIDTH=3):
- Reset, ready=0 for 3 frames -> an=1111 and seg=1111111 throughout; frame pulses every 32 cycles; no pulse in the first frame's first cycle.
- ready=1 with A..D=1,2,3,4 over the first boundary -> next frame:
  - Slot A: an=1111 for 2 cycles, then an=0111, seg=1001111 for 6 cycles.
  - Slot D: an=1110, seg=1001100.
  - All values observed with the 1-cycle output latency.
- Inputs change to 9,8,7,6 mid-frame with ready=1 -> current frame still shows 1,2,3,4; the following frame shows 9 (0000100) ... 6 (0100000).
- D=4'hC latched -> slot D drives seg=1111110.
- rst pulsed mid-slot while displaying -> next cycle an=1111, seg=1111111, frame=0. Display stays dark until a later boundary sees ready=1.
- Shadow 0,0,0,7:
  - Macro defined: only an[0] ever goes low, with seg=0001111.
  - Shadow 0,0,0,0 with macro defined: D shows 0000001.
  - Macro undefined: all four slots show 0000001.
